// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment register display.
// State encoding, hex segment table and blanking patterns.
package ssd_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_ssd.sv
// Combinational nibble to active-low segment decoder.
// Pure table lookup; no state.
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/ssd_reg_display.sv
// Frame-synchronous hex register viewer on a 4-digit muxed display.
// Optional SSD_AUTO_ALTERNATE_EN: auto-toggle shown half every ALT_FRAMES.
module ssd_reg_display
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_FRAMES = 2,
  parameter int ALT_FRAMES   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] reg_value,
  input  logic [4:0]  switch_register,
  input  logic        half_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLANK_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_FRAMES - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [4:0]    idx_q, idx_d;
  logic          half_q, half_d;
  state_t        state_q, state_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;

  logic       slot_end;
  logic       frame_end;
  logic       idx_change;
  logic [3:0] nibble;
  logic [6:0] seg_hex;

  assign slot_end   = (div_cnt_q == DIV_LAST);
  assign frame_end  = slot_end && (digit_idx_q == 2'd3);
  assign idx_change = frame_end && (switch_register != idx_q);

  // Refresh divider, frame capture and blanking FSM next state
  always_comb begin
    div_cnt_d   = slot_end ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = slot_end ? digit_idx_q + 2'd1 : digit_idx_q;
    shadow_d    = frame_end ? reg_value : shadow_q;
    idx_d       = idx_change ? switch_register : idx_q;
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    if (idx_change) begin
      state_d     = ST_BLANK;
      blank_cnt_d = BLANK_LOAD;
    end else if (frame_end && state_q == ST_BLANK) begin
      if (blank_cnt_q == '0) state_d = ST_SHOW;
      else blank_cnt_d = blank_cnt_q - 1'b1;
    end
  end

`ifdef SSD_AUTO_ALTERNATE_EN
  localparam int AW = $clog2(ALT_FRAMES + 1);
  localparam logic [AW-1:0] ALT_LAST = AW'(ALT_FRAMES - 1);

  logic [AW-1:0] alt_cnt_q, alt_cnt_d;
  logic          unused_half_sel;

  assign unused_half_sel = half_sel;

  // Frame counter flips the shown half; restarts on index change
  always_comb begin
    alt_cnt_d = alt_cnt_q;
    half_d    = half_q;
    if (idx_change) begin
      alt_cnt_d = '0;
    end else if (frame_end) begin
      if (alt_cnt_q == ALT_LAST) begin
        alt_cnt_d = '0;
        half_d    = ~half_q;
      end else begin
        alt_cnt_d = alt_cnt_q + 1'b1;
      end
    end
  end

  // Alternate counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) alt_cnt_q <= '0;
    else alt_cnt_q <= alt_cnt_d;
  end
`else
  localparam int unused_alt_frames = ALT_FRAMES;

  // Half latch follows the switch, sampled at frame boundaries
  always_comb begin
    half_d = frame_end ? half_sel : half_q;
  end
`endif

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      digit_idx_q <= 2'd0;
      shadow_q    <= '0;
      idx_q       <= '0;
      half_q      <= 1'b0;
      state_q     <= ST_BLANK;
      blank_cnt_q <= BLANK_LOAD;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      half_q      <= half_d;
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  assign nibble = shadow_q[{half_q, digit_idx_q, 2'b00} +: 4];

  hex_to_ssd u_hex (
    .nibble (nibble),
    .seg    (seg_hex)
  );

  // Drive display; anode held off in first cycle of each slot
  always_comb begin
    an         = AN_OFF;
    seg        = SEG_OFF;
    dp         = 1'b1;
    frame_tick = frame_end;
    if (state_q == ST_SHOW) begin
      seg = seg_hex;
      if (div_cnt_q != '0) begin
        an = ~(4'b0001 << digit_idx_q);
        dp = ~(half_q && digit_idx_q == 2'd0);
      end
    end
  end

endmodule
